gateway_cluster_arb: RTL and testbench

- Parametrised successor to the fixed two-node gateway cluster.
- Lets N_CH independent byte-stream clients share one mem_gateway instance.
- Each channel has a packet-admission FIFO; a round-robin arbiter serialises whole packets onto the gateway port.
- Gateway return bytes are routed back to the originating channel after the known pipeline latency N_LAT.

---
 rtl/cluster_pkg.sv | 27 ++
 rtl/gw_chan_fifo.sv | 139 +++++++++++++
 rtl/gateway_cluster_arb.sv | 173 +++++++++++++++++
 tb/tb_gateway_cluster_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_pkg.sv
// Shared types and constants for the gateway cluster: client port bundles,
// length width, default channel count and the FSM state encodings.
package cluster_pkg;

    localparam int LEN_W     = 11;
    localparam int CLUSTER_N = 2;

    typedef struct packed {
        logic [LEN_W-1:0] len_c;
        logic [7:0]       idata;
        logic             raw_l;
        logic             raw_s;
    } client_in_t;

    typedef struct packed {
        logic [7:0] odata;
    } client_out_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_GAP} arb_state_t;

    typedef enum logic [1:0] {ADM_WAIT, ADM_ACCEPT, ADM_REJECT} adm_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gw_chan_fifo.sv
// One client channel: packet admission, byte FIFO with per-byte last flags,
// queue of completed packet lengths and a saturating dropped-packet counter.
module gw_chan_fifo
    import cluster_pkg::*;
#(
    parameter int FIFO_AW = 6,
    parameter int PKT_AW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  client_in_t       cin,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_last,
    output logic             pkt_avail,
    output logic [LEN_W-1:0] pkt_len,
    output logic [7:0]       drop_cnt
);
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int PDEPTH = 1 << PKT_AW;

    logic [7:0]       mem_q  [DEPTH];
    logic             last_q [DEPTH];
    logic [LEN_W-1:0] lq_q   [PDEPTH];

    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PKT_AW:0]  lq_wr_q, lq_wr_d, lq_rd_q, lq_rd_d;
    adm_state_t       st_q, st_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [7:0]       drop_q, drop_d;

    logic [FIFO_AW:0]   occ;
    logic [LEN_W-1:0]   free_sp, push_len;
    logic [FIFO_AW-1:0] wr_idx, prev_idx;
    logic               lq_full, strobe, admit, wr_en, wr_last, patch, push;

    // Free space uses the occupancy at the start of the cycle, ignoring a concurrent pop.
    assign occ      = wr_ptr_q - rd_ptr_q;
    assign free_sp  = LEN_W'(DEPTH) - LEN_W'(occ);
    assign lq_full  = (lq_wr_q[PKT_AW] != lq_rd_q[PKT_AW]) &&
                      (lq_wr_q[PKT_AW-1:0] == lq_rd_q[PKT_AW-1:0]);
    assign strobe   = cin.raw_l && cin.raw_s;
    assign admit    = (cin.len_c != '0) && (cin.len_c <= free_sp) && !lq_full;
    assign wr_idx   = wr_ptr_q[FIFO_AW-1:0];
    assign prev_idx = wr_idx - FIFO_AW'(1);

    always_comb begin
        st_d     = st_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        wr_en    = 1'b0;
        wr_last  = 1'b0;
        patch    = 1'b0;
        push     = 1'b0;
        push_len = cnt_q;
        case (st_q)
            ADM_WAIT: begin
                if (strobe) begin
                    if (admit) begin
                        wr_en   = 1'b1;
                        wr_last = (cin.len_c == LEN_W'(1));
                        push    = wr_last;
                        push_len = LEN_W'(1);
                        cnt_d   = LEN_W'(1);
                        len_d   = cin.len_c;
                        st_d    = ADM_ACCEPT;
                    end else begin
                        drop_d = sat_inc8(drop_q);
                        st_d   = ADM_REJECT;
                    end
                end
            end
            ADM_ACCEPT: begin
                if (!cin.raw_l) begin
                    st_d = ADM_WAIT;
                    // Short packet: re-flag the last written byte and queue the real count.
                    if (cnt_q != len_q) begin
                        patch = 1'b1;
                        push  = 1'b1;
                    end
                end else if (cin.raw_s && (cnt_q != len_q)) begin
                    wr_en   = 1'b1;
                    cnt_d   = cnt_q + LEN_W'(1);
                    wr_last = (cnt_d == len_q);
                    push    = wr_last;
                    push_len = len_q;
                end
            end
            default: begin
                if (!cin.raw_l) st_d = ADM_WAIT;
            end
        endcase
    end

    assign rd_data   = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign rd_last   = last_q[rd_ptr_q[FIFO_AW-1:0]];
    assign pkt_avail = (lq_wr_q != lq_rd_q);
    assign pkt_len   = lq_q[lq_rd_q[PKT_AW-1:0]];
    assign drop_cnt  = drop_q;

    assign wr_ptr_d = wr_en ? wr_ptr_q + (FIFO_AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = rd_en ? rd_ptr_q + (FIFO_AW+1)'(1) : rd_ptr_q;
    assign lq_wr_d  = push ? lq_wr_q + (PKT_AW+1)'(1) : lq_wr_q;
    assign lq_rd_d  = (rd_en && rd_last) ? lq_rd_q + (PKT_AW+1)'(1) : lq_rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx]  <= cin.idata;
            last_q[wr_idx] <= wr_last;
        end else if (patch) begin
            last_q[prev_idx] <= 1'b1;
        end
        if (push) lq_q[lq_wr_q[PKT_AW-1:0]] <= push_len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lq_wr_q  <= '0;
            lq_rd_q  <= '0;
            st_q     <= ADM_WAIT;
            len_q    <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lq_wr_q  <= lq_wr_d;
            lq_rd_q  <= lq_rd_d;
            st_q     <= st_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: rtl/gateway_cluster_arb.sv
// N_CH byte-stream clients sharing one gateway: round-robin whole-packet
// arbitration onto the gateway port and latency-matched reply routing.
module gateway_cluster_arb
    import cluster_pkg::*;
#(
    parameter int N_CH    = CLUSTER_N,
    parameter int FIFO_AW = 6,
    parameter int PKT_AW  = 2,
    parameter int N_LAT   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_W*N_CH-1:0] in_len_c,
    input  logic [8*N_CH-1:0]     in_idata,
    input  logic [N_CH-1:0]       in_raw_l,
    input  logic [N_CH-1:0]       in_raw_s,
    output logic [LEN_W-1:0]      gw_len_c,
    output logic [7:0]            gw_idata,
    output logic                  gw_raw_l,
    output logic                  gw_raw_s,
    input  logic [7:0]            gw_odata,
    output logic [7:0]            out_odata,
    output logic [N_CH-1:0]       out_strobe,
    output logic                  out_last,
    output logic [8*N_CH-1:0]     drop_cnt
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [7:0]       ch_data [N_CH];
    logic [LEN_W-1:0] ch_len  [N_CH];
    logic [N_CH-1:0]  ch_last, ch_avail, ch_rd;

    arb_state_t       state_q, state_d;
    logic [CH_W-1:0]  grant_q, grant_d, ptr_q, ptr_d, gw_ch_q, gw_ch_d, pick;
    logic [LEN_W-1:0] gw_len_q, gw_len_d;
    logic [7:0]       gw_idata_q, gw_idata_d;
    logic             gw_raw_l_q, gw_raw_l_d, gw_raw_s_q, gw_raw_s_d, gw_last_q, gw_last_d;
    logic             found;
    logic [CH_W:0]    rr_sum;

    logic [N_LAT-1:0]           dl_vld_q, dl_vld_d, dl_last_q, dl_last_d;
    logic [N_LAT-1:0][CH_W-1:0] dl_ch_q, dl_ch_d;
    client_out_t                hold_q, hold_d;
    logic                       ret_vld;

    genvar gi;
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
        client_in_t cin;
        assign cin = {in_len_c[gi*LEN_W +: LEN_W], in_idata[gi*8 +: 8], in_raw_l[gi], in_raw_s[gi]};
        assign ch_rd[gi] = (state_q == ARB_SEND) && (grant_q == CH_W'(gi));

        gw_chan_fifo #(.FIFO_AW(FIFO_AW), .PKT_AW(PKT_AW)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .cin       (cin),
            .rd_en     (ch_rd[gi]),
            .rd_data   (ch_data[gi]),
            .rd_last   (ch_last[gi]),
            .pkt_avail (ch_avail[gi]),
            .pkt_len   (ch_len[gi]),
            .drop_cnt  (drop_cnt[gi*8 +: 8])
        );
    end

    // First eligible channel scanning upward from the pointer, wrapping mod N_CH.
    always_comb begin
        pick   = ptr_q;
        found  = 1'b0;
        rr_sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            rr_sum = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (rr_sum >= (CH_W+1)'(N_CH)) rr_sum = rr_sum - (CH_W+1)'(N_CH);
            if (!found && ch_avail[rr_sum[CH_W-1:0]]) begin
                found = 1'b1;
                pick  = rr_sum[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        gw_ch_d    = gw_ch_q;
        gw_len_d   = '0;
        gw_idata_d = '0;
        gw_raw_l_d = 1'b0;
        gw_raw_s_d = 1'b0;
        gw_last_d  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ARB_SEND;
                end
            end
            ARB_SEND: begin
                gw_raw_l_d = 1'b1;
                gw_raw_s_d = 1'b1;
                gw_idata_d = ch_data[grant_q];
                gw_len_d   = ch_len[grant_q];
                gw_last_d  = ch_last[grant_q];
                gw_ch_d    = grant_q;
                if (ch_last[grant_q]) begin
                    state_d = ARB_GAP;
                    ptr_d   = (grant_q == CH_W'(N_CH-1)) ? '0 : grant_q + CH_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Return tags travel alongside the bytes so they line up with gw_odata.
    for (gi = 0; gi < N_LAT; gi++) begin : g_dl
        if (gi == 0) begin : g_head
            assign dl_vld_d[gi]  = gw_raw_s_q;
            assign dl_last_d[gi] = gw_last_q;
            assign dl_ch_d[gi]   = gw_ch_q;
        end else begin : g_tail
            assign dl_vld_d[gi]  = dl_vld_q[gi-1];
            assign dl_last_d[gi] = dl_last_q[gi-1];
            assign dl_ch_d[gi]   = dl_ch_q[gi-1];
        end
    end

    assign ret_vld      = dl_vld_q[N_LAT-1];
    assign hold_d.odata = ret_vld ? gw_odata : hold_q.odata;
    assign out_odata    = hold_d.odata;
    assign out_last     = ret_vld && dl_last_q[N_LAT-1];

    always_comb begin
        out_strobe = '0;
        if (ret_vld) out_strobe[dl_ch_q[N_LAT-1]] = 1'b1;
    end

    assign gw_len_c = gw_len_q;
    assign gw_idata = gw_idata_q;
    assign gw_raw_l = gw_raw_l_q;
    assign gw_raw_s = gw_raw_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            gw_ch_q    <= '0;
            gw_len_q   <= '0;
            gw_idata_q <= '0;
            gw_raw_l_q <= 1'b0;
            gw_raw_s_q <= 1'b0;
            gw_last_q  <= 1'b0;
            dl_vld_q   <= '0;
            dl_last_q  <= '0;
            dl_ch_q    <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            gw_ch_q    <= gw_ch_d;
            gw_len_q   <= gw_len_d;
            gw_idata_q <= gw_idata_d;
            gw_raw_l_q <= gw_raw_l_d;
            gw_raw_s_q <= gw_raw_s_d;
            gw_last_q  <= gw_last_d;
            dl_vld_q   <= dl_vld_d;
            dl_last_q  <= dl_last_d;
            dl_ch_q    <= dl_ch_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: tb/tb_gateway_cluster_arb.sv
// Directed bench for gateway_cluster_arb with two channels, an 8-byte FIFO and
// a bench-side gateway model that returns each byte inverted after NL cycles.
module tb_gateway_cluster_arb;
    localparam int NCH = 2;
    localparam int FAW = 3;
    localparam int PAW = 2;
    localparam int NL  = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [11*NCH-1:0]  in_len_c = '0;
    logic [8*NCH-1:0]   in_idata = '0;
    logic [NCH-1:0]     in_raw_l = '0;
    logic [NCH-1:0]     in_raw_s = '0;
    logic [10:0]        gw_len_c;
    logic [7:0]         gw_idata;
    logic               gw_raw_l, gw_raw_s;
    logic [7:0]         gw_odata;
    logic [7:0]         out_odata;
    logic [NCH-1:0]     out_strobe;
    logic               out_last;
    logic [8*NCH-1:0]   drop_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {int cyc; logic [7:0] d; logic [10:0] len; logic l;} gw_rec_t;
    typedef struct {int cyc; logic [7:0] d; logic [1:0] s; logic last;} ret_rec_t;
    gw_rec_t  gw_q[$];
    ret_rec_t ret_q[$];

    gateway_cluster_arb #(.N_CH(NCH), .FIFO_AW(FAW), .PKT_AW(PAW), .N_LAT(NL)) dut (
        .clk(clk), .rst(rst),
        .in_len_c(in_len_c), .in_idata(in_idata), .in_raw_l(in_raw_l), .in_raw_s(in_raw_s),
        .gw_len_c(gw_len_c), .gw_idata(gw_idata), .gw_raw_l(gw_raw_l), .gw_raw_s(gw_raw_s),
        .gw_odata(gw_odata), .out_odata(out_odata), .out_strobe(out_strobe),
        .out_last(out_last), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gateway model: fixed NL-cycle pipeline returning the inverted byte.
    logic [7:0] pipe [NL];
    always @(posedge clk) begin
        pipe[0] <= gw_idata ^ 8'hFF;
        for (int i = 1; i < NL; i++) pipe[i] <= pipe[i-1];
    end
    assign gw_odata = pipe[NL-1];

    always @(negedge clk) begin
        gw_rec_t  g;
        ret_rec_t r;
        if (gw_raw_s) begin
            g.cyc = cyc; g.d = gw_idata; g.len = gw_len_c; g.l = gw_raw_l;
            gw_q.push_back(g);
            $display("gw  cyc=%0d byte=%02h len=%0d raw_l=%0b", cyc, gw_idata, gw_len_c, gw_raw_l);
        end
        if (out_strobe != '0) begin
            r.cyc = cyc; r.d = out_odata; r.s = out_strobe; r.last = out_last;
            ret_q.push_back(r);
            $display("ret cyc=%0d byte=%02h strobe=%02b last=%0b", cyc, out_odata, out_strobe, out_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_mon();
        gw_q.delete();
        ret_q.delete();
    endtask

    task automatic send_pkt(input int ch, input int len_decl, input int nbytes,
                            input logic [7:0] base, input logic [7:0] step);
        in_len_c[ch*11 +: 11] = 11'(len_decl);
        in_raw_l[ch] = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            in_idata[ch*8 +: 8] = base + step * 8'(i);
            in_raw_s[ch] = 1'b1;
            tick();
        end
        in_raw_s[ch] = 1'b0;
        in_raw_l[ch] = 1'b0;
        in_len_c[ch*11 +: 11] = '0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_total++; if ({gw_raw_l, gw_raw_s, out_last} !== 3'b000) $display("FAIL reset_flags got %03b want 000", {gw_raw_l, gw_raw_s, out_last}); else n_pass++;
        n_total++; if ({gw_len_c, gw_idata, out_odata} !== 27'd0) $display("FAIL reset_data got %h want 0", {gw_len_c, gw_idata, out_odata}); else n_pass++;
        n_total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop got %h want 0000", drop_cnt); else n_pass++;
        rst = 1'b0;
        idle(5);
        n_total++; if ({out_strobe, gw_raw_s} !== 3'b000) $display("FAIL reset_idle got %03b want 000", {out_strobe, gw_raw_s}); else n_pass++;
    endtask

    task automatic test_both_channels();
        logic [7:0] exp_b [6];
        exp_b = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
        clear_mon();
        in_len_c = {11'd3, 11'd3};
        in_raw_l = 2'b11;
        for (int i = 0; i < 3; i++) begin
            in_idata = {8'hB1 + 8'(i), 8'hA1 + 8'(i)};
            in_raw_s = 2'b11;
            tick();
        end
        in_raw_s = '0; in_raw_l = '0; in_len_c = '0;
        idle(50);
        n_total++; if (gw_q.size() !== 6) $display("FAIL both_gw_count got %0d want 6", gw_q.size()); else n_pass++;
        n_total++; if (ret_q.size() !== 6) $display("FAIL both_ret_count got %0d want 6", ret_q.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (i < gw_q.size()) begin
                n_total++; if (gw_q[i].d !== exp_b[i]) $display("FAIL both_gw_byte%0d got %02h want %02h", i, gw_q[i].d, exp_b[i]); else n_pass++;
            end
            if (i < ret_q.size() && i < gw_q.size()) begin
                n_total++; if (ret_q[i].s !== ((i < 3) ? 2'b01 : 2'b10)) $display("FAIL both_ret_strobe%0d got %02b want %02b", i, ret_q[i].s, (i < 3) ? 2'b01 : 2'b10); else n_pass++;
                n_total++; if (ret_q[i].last !== (i == 2 || i == 5)) $display("FAIL both_ret_last%0d got %0b want %0b", i, ret_q[i].last, (i == 2 || i == 5)); else n_pass++;
                n_total++; if (ret_q[i].cyc !== gw_q[i].cyc + NL) $display("FAIL both_ret_lat%0d got %0d want %0d", i, ret_q[i].cyc - gw_q[i].cyc, NL); else n_pass++;
            end
        end
        if (gw_q.size() >= 4) begin
            n_total++; if (gw_q[3].cyc - gw_q[2].cyc !== 3) $display("FAIL both_gap got %0d want 3", gw_q[3].cyc - gw_q[2].cyc); else n_pass++;
        end
    endtask

    task automatic test_single_packet();
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_mon();
        send_pkt(0, 4, 4, 8'h11, 8'h11);
        idle(40);
        n_total++; if (gw_q.size() !== 4) $display("FAIL single_gw_count got %0d want 4", gw_q.size()); else n_pass++;
        n_total++; if (ret_q.size() !== 4) $display("FAIL single_ret_count got %0d want 4", ret_q.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (i < gw_q.size()) begin
                n_total++; if (gw_q[i].d !== exp_b[i]) $display("FAIL single_gw_byte%0d got %02h want %02h", i, gw_q[i].d, exp_b[i]); else n_pass++;
                n_total++; if (gw_q[i].len !== 11'd4 || gw_q[i].l !== 1'b1) $display("FAIL single_gw_len%0d got %0d/%0b want 4/1", i, gw_q[i].len, gw_q[i].l); else n_pass++;
                n_total++; if (gw_q[i].cyc !== gw_q[0].cyc + i) $display("FAIL single_gw_consec%0d got %0d want %0d", i, gw_q[i].cyc - gw_q[0].cyc, i); else n_pass++;
            end
            if (i < ret_q.size() && i < gw_q.size()) begin
                n_total++; if (ret_q[i].d !== (exp_b[i] ^ 8'hFF)) $display("FAIL single_ret_byte%0d got %02h want %02h", i, ret_q[i].d, exp_b[i] ^ 8'hFF); else n_pass++;
                n_total++; if (ret_q[i].s !== 2'b01 || ret_q[i].last !== (i == 3)) $display("FAIL single_ret_tag%0d got %02b/%0b want 01/%0b", i, ret_q[i].s, ret_q[i].last, (i == 3)); else n_pass++;
                n_total++; if (ret_q[i].cyc !== gw_q[i].cyc + NL) $display("FAIL single_ret_lat%0d got %0d want %0d", i, ret_q[i].cyc - gw_q[i].cyc, NL); else n_pass++;
            end
        end
    endtask

    task automatic test_overflow_drop();
        clear_mon();
        send_pkt(1, 6, 6, 8'h61, 8'h01);
        send_pkt(1, 6, 6, 8'h71, 8'h01);
        idle(40);
        n_total++; if (drop_cnt[15:8] !== 8'd1) $display("FAIL drop_cnt1 got %0d want 1", drop_cnt[15:8]); else n_pass++;
        n_total++; if (drop_cnt[7:0] !== 8'd0) $display("FAIL drop_cnt0 got %0d want 0", drop_cnt[7:0]); else n_pass++;
        n_total++; if (gw_q.size() !== 6) $display("FAIL drop_gw_count got %0d want 6", gw_q.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (i < gw_q.size()) begin
                n_total++; if (gw_q[i].d !== 8'h61 + 8'(i)) $display("FAIL drop_gw_byte%0d got %02h want %02h", i, gw_q[i].d, 8'h61 + 8'(i)); else n_pass++;
            end
            if (i < ret_q.size()) begin
                n_total++; if (ret_q[i].s !== 2'b10 || ret_q[i].last !== (i == 5)) $display("FAIL drop_ret_tag%0d got %02b/%0b want 10/%0b", i, ret_q[i].s, ret_q[i].last, (i == 5)); else n_pass++;
            end
        end
    endtask

    task automatic test_truncate();
        clear_mon();
        send_pkt(0, 5, 2, 8'h51, 8'h01);
        idle(40);
        n_total++; if (gw_q.size() !== 2) $display("FAIL trunc_gw_count got %0d want 2", gw_q.size()); else n_pass++;
        n_total++; if (ret_q.size() !== 2) $display("FAIL trunc_ret_count got %0d want 2", ret_q.size()); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            if (i < gw_q.size()) begin
                n_total++; if (gw_q[i].len !== 11'd2) $display("FAIL trunc_gw_len%0d got %0d want 2", i, gw_q[i].len); else n_pass++;
                n_total++; if (gw_q[i].d !== 8'h51 + 8'(i)) $display("FAIL trunc_gw_byte%0d got %02h want %02h", i, gw_q[i].d, 8'h51 + 8'(i)); else n_pass++;
            end
            if (i < ret_q.size()) begin
                n_total++; if (ret_q[i].s !== 2'b01 || ret_q[i].last !== (i == 1)) $display("FAIL trunc_ret_tag%0d got %02b/%0b want 01/%0b", i, ret_q[i].s, ret_q[i].last, (i == 1)); else n_pass++;
            end
        end
    endtask

    task automatic test_saturate();
        clear_mon();
        send_pkt(0, 0, 1, 8'h00, 8'h00);
        n_total++; if (drop_cnt[7:0] !== 8'd1) $display("FAIL sat_zero_len got %0d want 1", drop_cnt[7:0]); else n_pass++;
        repeat (254) send_pkt(0, 9, 1, 8'h00, 8'h00);
        n_total++; if (drop_cnt[7:0] !== 8'd255) $display("FAIL sat_reach got %0d want 255", drop_cnt[7:0]); else n_pass++;
        repeat (46) send_pkt(0, 9, 1, 8'h00, 8'h00);
        n_total++; if (drop_cnt[7:0] !== 8'd255) $display("FAIL sat_hold got %0d want 255", drop_cnt[7:0]); else n_pass++;
        n_total++; if (drop_cnt[15:8] !== 8'd1) $display("FAIL sat_other_ch got %0d want 1", drop_cnt[15:8]); else n_pass++;
        idle(20);
        n_total++; if (gw_q.size() !== 0) $display("FAIL sat_gw_count got %0d want 0", gw_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        int n;
        clear_mon();
        send_pkt(1, 8, 8, 8'h81, 8'h01);
        n = 0;
        for (int k = 0; k < 60 && n < 3; k++) begin
            @(negedge clk);
            if (gw_raw_s) n++;
        end
        n_total++; if (n !== 3) $display("FAIL rstmid_wait got %0d want 3 strobes", n); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if ({gw_raw_l, gw_raw_s, out_strobe, out_last} !== 5'd0) $display("FAIL rstmid_flags got %05b want 00000", {gw_raw_l, gw_raw_s, out_strobe, out_last}); else n_pass++;
        n_total++; if ({gw_len_c, gw_idata, out_odata} !== 27'd0) $display("FAIL rstmid_data got %h want 0", {gw_len_c, gw_idata, out_odata}); else n_pass++;
        n_total++; if (drop_cnt !== 16'd0) $display("FAIL rstmid_drop got %h want 0000", drop_cnt); else n_pass++;
        tick();
        rst = 1'b0;
        clear_mon();
        idle(40);
        n_total++; if (ret_q.size() !== 0) $display("FAIL rstmid_ret_count got %0d want 0", ret_q.size()); else n_pass++;
        n_total++; if (gw_q.size() !== 0) $display("FAIL rstmid_gw_count got %0d want 0", gw_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_both_channels();
        test_single_packet();
        test_overflow_drop();
        test_truncate();
        test_saturate();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
